luces_modos: RTL and testbench

Parametrised light sequencer with four selectable run durations, pause, abort and an acknowledge-to-restart final state. It sits beside the single-run light controller in the lab design and drives the same three lamps, plus a completion pulse and status for a supervising block.

---
 rtl/luces_pkg.sv | 38 +++
 rtl/luces_modos_contador_dur.sv | 34 +++
 rtl/luces_modos.sv | 124 ++++++++++++
 tb/tb_luces_modos.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/luces_pkg.sv
`default_nettype none
// ============================================================================
// Module   : luces_pkg
// Purpose  : Shared definitions for the luces_modos light sequencer. It holds
//            the state encoding, the mode constants and the mode-to-duration
//            lookup.
// Revision : 1.0 - initial release
// ============================================================================
package luces_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    PAUSA = 3'b010,
    FINAL = 3'b100
  } state_t;

  localparam logic [1:0] M_RAPIDO = 2'd0;
  localparam logic [1:0] M_NORMAL = 2'd1;
  localparam logic [1:0] M_LENTO  = 2'd2;
  localparam logic [1:0] M_LENTO2 = 2'd3;

  // Returns the run length in cycles for the selected mode.
  function automatic int dur_for(input logic [1:0] mode,
                                 input int d0, input int d1,
                                 input int d2, input int d3);
    int d;
    case (mode)
      M_RAPIDO: d = d0;
      M_NORMAL: d = d1;
      M_LENTO:  d = d2;
      default:  d = d3;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/luces_modos_contador_dur.sv
`default_nettype none
// ============================================================================
// Module   : contador_dur
// Purpose  : Run-length counter for luces_modos. The counter clears to zero,
//            advances by one when enabled and flags the terminal value.
// Ports    : clk, reset (sync, active-high), clear, enable,
//            terminal[CNT_W] (last count value of the run),
//            cuenta[CNT_W] (current count), at_terminal
// Revision : 1.0 - initial release
// ============================================================================
module contador_dur #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] cuenta,
  output logic             at_terminal
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cuenta <= '0;
    end else if (enable) begin
      cuenta <= cuenta + CNT_W'(1);
    end
  end

  assign at_terminal = (cuenta == terminal);

endmodule
`default_nettype wire

// File: rtl/luces_modos.sv
`default_nettype none
// ============================================================================
// Module   : luces_modos
// Purpose  : Light sequencer with four selectable run durations, pause, abort
//            and an acknowledge-to-restart final state.
// Ports    : CLK, RESET (sync, active-high), START, MODE[2], PAUSE, ABORT,
//            ACK -> LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE, DONE (1-cycle pulse),
//            MODE_ACT[2], CUENTA[CNT_W]
// Params   : CNT_W counter width; DUR0..DUR3 run lengths, 1..2**CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module luces_modos
  import luces_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int DUR0  = 10,
  parameter int DUR1  = 20,
  parameter int DUR2  = 30,
  parameter int DUR3  = 40
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic             PAUSE,
  input  logic             ABORT,
  input  logic             ACK,
  output logic             LUZ_ROJA,
  output logic             LUZ_AMARILLA,
  output logic             LUZ_VERDE,
  output logic             DONE,
  output logic [1:0]       MODE_ACT,
  output logic [CNT_W-1:0] CUENTA
);

  state_t           state;
  state_t           next_state;
  logic [1:0]       mode_act;
  logic             done;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             at_terminal;
  logic [CNT_W-1:0] terminal;

  // Last count value of the run; DUR <= 2**CNT_W so DUR-1 always fits.
  assign terminal = CNT_W'(dur_for(mode_act, DUR0, DUR1, DUR2, DUR3) - 1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      mode_act <= M_RAPIDO;
      done     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && START) begin
        mode_act <= MODE;
      end
      done <= (state == RUN) && (next_state == FINAL);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (START) next_state = RUN;
      RUN: begin
        if (ABORT)            next_state = IDLE;
        else if (PAUSE)       next_state = PAUSA;
        else if (at_terminal) next_state = FINAL;
      end
      PAUSA: begin
        if (ABORT)       next_state = IDLE;
        else if (!PAUSE) next_state = RUN;
      end
      FINAL: if (ACK) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The count only advances on RUN->RUN edges: entering PAUSA and leaving it
  // both hold the value, so the run resumes exactly where it stopped.
  assign cnt_enable = (state == RUN) && (next_state == RUN);
  assign cnt_clear  = (next_state == IDLE) || (next_state == FINAL);

  contador_dur #(
    .CNT_W(CNT_W)
  ) u_contador (
    .clk        (CLK),
    .reset      (RESET),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .terminal   (terminal),
    .cuenta     (CUENTA),
    .at_terminal(at_terminal)
  );

  // Modes 0/1 run on green, modes 2/3 on yellow.
  always_comb begin
    LUZ_ROJA     = 1'b1;
    LUZ_AMARILLA = 1'b0;
    LUZ_VERDE    = 1'b0;
    case (state)
      RUN: begin
        LUZ_ROJA     = 1'b0;
        LUZ_AMARILLA = mode_act[1];
        LUZ_VERDE    = ~mode_act[1];
      end
      PAUSA: begin
        LUZ_AMARILLA = mode_act[1];
        LUZ_VERDE    = ~mode_act[1];
      end
      FINAL: begin
        LUZ_AMARILLA = 1'b1;
        LUZ_VERDE    = 1'b1;
      end
      default: ;
    endcase
  end

  assign DONE     = done;
  assign MODE_ACT = mode_act;

endmodule
`default_nettype wire

// File: tb/tb_luces_modos.sv
`default_nettype none
// ============================================================================
// Module   : tb_luces_modos
// Purpose  : Directed self-checking bench for luces_modos.
// Revision : 1.0 - initial release
// ============================================================================
module tb_luces_modos;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       ack = 1'b0;
  logic       luz_roja, luz_amarilla, luz_verde, done;
  logic [1:0] mode_act;
  logic [5:0] cuenta;

  int errors = 0;
  int checks = 0;
  int n;
  int total;
  logic flag;

  always #5 clk = ~clk;

  luces_modos dut (
    .CLK         (clk),
    .RESET       (reset),
    .START       (start),
    .MODE        (mode),
    .PAUSE       (pause),
    .ABORT       (abort),
    .ACK         (ack),
    .LUZ_ROJA    (luz_roja),
    .LUZ_AMARILLA(luz_amarilla),
    .LUZ_VERDE   (luz_verde),
    .DONE        (done),
    .MODE_ACT    (mode_act),
    .CUENTA      (cuenta)
  );

  // Lamps packed as {red, yellow, green}.
  function automatic logic [2:0] lamps();
    return {luz_roja, luz_amarilla, luz_verde};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles until the all-on FINAL lamps appear (current cycle included).
  task automatic run_to_final(output int cyc);
    cyc = 0;
    while (lamps() != 3'b111 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lamps"}, 32'(lamps()), 32'b100);
    check({tag, "_cuenta"}, 32'(cuenta), 0);
    check({tag, "_mode_act"}, 32'(mode_act), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // MODE 0: green for 10 cycles
    mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
    check("m0_first_lamps", 32'(lamps()), 32'b001);
    check("m0_first_cuenta", 32'(cuenta), 0);
    run_to_final(n);
    check("m0_run_len", n, 10);
    check("m0_final_done", 32'(done), 1);
    check("m0_final_cuenta", 32'(cuenta), 0);
    tick();
    check("m0_done_pulse", 32'(done), 0);
    check("m0_final_lamps", 32'(lamps()), 32'b111);
    ack = 1'b1; tick(); ack = 1'b0;
    check("m0_ack_idle", 32'(lamps()), 32'b100);

    // MODE 3: yellow for 40 cycles while MODE toggles
    mode = 2'd3; start = 1'b1; tick(); start = 1'b0;
    check("m3_lamps", 32'(lamps()), 32'b010);
    n = 0;
    while (lamps() != 3'b111 && n < 200) begin
      mode = mode + 2'd1;
      n++;
      tick();
    end
    check("m3_run_len", n, 40);
    check("m3_mode_act", 32'(mode_act), 3);
    check("m3_done", 32'(done), 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // MODE 1 with pause at CUENTA=7: 20 counting cycles, 4 PAUSA cycles and
    // one repeated RUN cycle at 7 give 25 cycles of RUN+PAUSA.
    mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
    total = 1;
    repeat (7) begin tick(); total++; end
    check("p_cuenta7", 32'(cuenta), 7);
    pause = 1'b1;
    flag = 1'b1;
    repeat (4) begin
      tick(); total++;
      if (lamps() != 3'b101 || cuenta != 6'd7) flag = 1'b0;
    end
    check("p_red_green_frozen", 32'(flag), 1);
    pause = 1'b0;
    tick(); total++;
    check("p_resume_lamps", 32'(lamps()), 32'b001);
    check("p_resume_cuenta", 32'(cuenta), 7);
    run_to_final(n);
    total = total + n - 1;
    check("p_total", total, 25);
    ack = 1'b1; tick(); ack = 1'b0;

    // ABORT at CUENTA=4
    mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("ab_cuenta4", 32'(cuenta), 4);
    abort = 1'b1; tick(); abort = 1'b0;
    check("ab_lamps", 32'(lamps()), 32'b100);
    check("ab_cuenta", 32'(cuenta), 0);
    flag = 1'b1;
    repeat (12) begin
      if (done !== 1'b0 || lamps() != 3'b100) flag = 1'b0;
      tick();
    end
    check("ab_no_done_stay_idle", 32'(flag), 1);

    // ABORT and PAUSE together
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1; pause = 1'b1; tick(); abort = 1'b0; pause = 1'b0;
    check("abp_lamps", 32'(lamps()), 32'b100);
    check("abp_cuenta", 32'(cuenta), 0);
    check("abp_done", 32'(done), 0);

    // FINAL hold with ACK=0 and START ignored, then ACK with START held
    mode = 2'd2; start = 1'b1; tick(); start = 1'b0;
    run_to_final(n);
    check("f_run_len", n, 30);
    start = 1'b1;
    flag = 1'b1;
    repeat (50) begin
      tick();
      if (lamps() != 3'b111) flag = 1'b0;
    end
    check("f_hold", 32'(flag), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("f_ack_idle", 32'(lamps()), 32'b100);
    tick(); start = 1'b0;
    check("f_restart_lamps", 32'(lamps()), 32'b010);
    check("f_restart_cuenta", 32'(cuenta), 0);

    // RESET in RUN
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("rst_run");

    // RESET in PAUSA
    mode = 2'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    pause = 1'b1; tick(); tick();
    check("rp_pausa", 32'(lamps()), 32'b101);
    reset = 1'b1; tick(); reset = 1'b0; pause = 1'b0;
    check_reset_vals("rst_pausa");

    // RESET in FINAL, on the DONE cycle
    mode = 2'd3; start = 1'b1; tick(); start = 1'b0;
    run_to_final(n);
    check("rf_done", 32'(done), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("rst_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
